// File: rtl/seq_barrel_rotator_pkg.sv
// +--------------------------------------------------------------------------+
// | rotator_pkg : shift modes and direction encodings for seq_barrel_rotator |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package rotator_pkg;

  typedef enum logic [1:0] {ROT = 2'b00, LSL = 2'b01, LSR = 2'b10, ASR = 2'b11} shift_mode_t;

  localparam bit DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_barrel_rotator_if.sv
// +--------------------------------------------------------------------------+
// | seq_barrel_rotator_if : switch/button inputs and display outputs         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface seq_barrel_rotator_if
  import rotator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) ();

  logic [WIDTH-1:0] data;
  logic             load;
  logic             btn_r;
  logic             btn_l;
  logic             btn_c;
  logic [AMT_W-1:0] amt;
  shift_mode_t      mode;
  logic             run_en;
  logic             run_dir;
  logic [WIDTH-1:0] shout;
  logic             op_done;

  modport master (
    output data, load, btn_r, btn_l, btn_c, amt, mode, run_en, run_dir,
    input  shout, op_done
  );

  modport slave (
    input  data, load, btn_r, btn_l, btn_c, amt, mode, run_en, run_dir,
    output shout, op_done
  );

endinterface

`default_nettype wire

// File: rtl/seq_barrel_rotator_shift_unit.sv
// +--------------------------------------------------------------------------+
// | shift_unit : combinational rotate / logical / arithmetic one-shot shift  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_unit
  import rotator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [AMT_W-1:0] step_i,
  input  logic             dir_i,
  input  shift_mode_t      mode_i,
  output logic [WIDTH-1:0] result_o
);

  logic [31:0] w_rot_amt;
  logic [31:0] w_rot_inv;

  // A complementary shift by WIDTH yields zero, so rot_amt == 0 passes word_i through.
  assign w_rot_amt = 32'(step_i) % 32'(WIDTH);
  assign w_rot_inv = 32'(WIDTH) - w_rot_amt;

  always_comb begin
    result_o = word_i;
    if (mode_i == ROT) begin
      if (dir_i == DIR_LEFT) begin
        result_o = (word_i << w_rot_amt) | (word_i >> w_rot_inv);
      end else begin
        result_o = (word_i >> w_rot_amt) | (word_i << w_rot_inv);
      end
    end else if (dir_i == DIR_LEFT) begin
      result_o = word_i << step_i;
    end else if (mode_i == ASR) begin
      result_o = $signed(word_i) >>> step_i;
    end else begin
      result_o = word_i >> step_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_barrel_rotator.sv
// +--------------------------------------------------------------------------+
// | seq_barrel_rotator : button-stepped barrel rotator, optional auto-rotate |
// | Optional feature macro: SEQ_ROTATOR_AUTORUN_EN. Rev 1.0                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_barrel_rotator
  import rotator_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int AMT_W    = $clog2(WIDTH),
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_barrel_rotator_if.slave   bus
);

  logic [WIDTH-1:0] shout_q;
  logic [WIDTH-1:0] shout_d;
  logic             op_done_q;
  logic             op_done_d;
  logic             btn_r_q;
  logic             btn_l_q;

  logic             w_rise_r;
  logic             w_rise_l;
  logic             w_tick;
  logic             w_auto_dir;
  logic             w_shift_dir;
  logic [AMT_W-1:0] w_step;
  logic [WIDTH-1:0] w_shift_res;

  assign w_rise_r    = bus.btn_r & ~btn_r_q;
  assign w_rise_l    = bus.btn_l & ~btn_l_q;
  assign w_step      = bus.btn_c ? bus.amt : AMT_W'(1);
  assign w_shift_dir = (w_rise_r ^ w_rise_l) ? (w_rise_l ? DIR_LEFT : DIR_RIGHT) : w_auto_dir;

`ifdef SEQ_ROTATOR_AUTORUN_EN
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    w_tick = 1'b0;
    if (!bus.run_en || bus.load) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
      cnt_d  = '0;
      w_tick = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign w_auto_dir = bus.run_dir;
`else
  logic w_unused_run;

  assign w_tick       = 1'b0;
  assign w_auto_dir   = DIR_RIGHT;
  assign w_unused_run = ^{bus.run_en, bus.run_dir, 32'(TICK_DIV)};
`endif

  shift_unit #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_shift_unit (
    .word_i   (shout_q),
    .step_i   (w_step),
    .dir_i    (w_shift_dir),
    .mode_i   (bus.mode),
    .result_o (w_shift_res)
  );

  // Any manual rise (even the cancelling left+right pair) swallows a coincident tick.
  always_comb begin
    shout_d   = shout_q;
    op_done_d = 1'b0;
    if (bus.load) begin
      shout_d = bus.data;
    end else if (w_rise_r ^ w_rise_l) begin
      shout_d   = w_shift_res;
      op_done_d = 1'b1;
    end else if (!(w_rise_r | w_rise_l) && w_tick) begin
      shout_d   = w_shift_res;
      op_done_d = 1'b1;
    end
  end

  // Button history resets high so a press held across reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      shout_q   <= '0;
      op_done_q <= 1'b0;
      btn_r_q   <= 1'b1;
      btn_l_q   <= 1'b1;
    end else begin
      shout_q   <= shout_d;
      op_done_q <= op_done_d;
      btn_r_q   <= bus.btn_r;
      btn_l_q   <= bus.btn_l;
    end
  end

  assign bus.shout   = shout_q;
  assign bus.op_done = op_done_q;

endmodule

`default_nettype wire
